// File: rtl/rroce_pkt_parser.sv
// rroce_pkt_parser: checks ETH/IPv4/UDP/BTH headers of a received RoCEv2 frame and strips
// them together with the trailing ICRC, realigning the payload onto a fresh 64-byte stream.
module rroce_pkt_parser #(
  parameter logic [23:0] PSN_INIT  = 24'h0,
  parameter logic [15:0] UDP_DPORT = 16'd4791
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [511:0] m_axis_tdata,
  output logic [63:0]  m_axis_tkeep,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         m_axis_tready,
  input  logic [23:0]  local_qp,
  output logic         hdr_valid,
  output logic [7:0]   hdr_opcode,
  output logic [23:0]  hdr_psn,
  output logic         hdr_ackreq,
  output logic [5:0]   hdr_err,
  output logic [15:0]  rx_good_cnt,
  output logic [15:0]  rx_drop_cnt
);
  typedef enum logic [1:0] {HDR, PAYLOAD, FLUSH, DROP} state_t;
  localparam logic [63:0] ONES = '1;
  state_t state_q, state_d;
  logic [23:0] psn_q;
  logic [79:0] hold_q;
  logic [2:0] fl_n_q;
  logic [19:0] csum;
  logic [16:0] fold;
  logic [6:0] n, r;
  logic [5:0] err;
  logic hdr_hs, emit;

  function automatic logic [7:0] b(input int i);
    return s_axis_tdata[8*i +: 8];
  endfunction

  // a short beat 0 (fewer than 58 bytes) cannot hold the headers, so it is flagged as a bad IP header
  always_comb begin
    n = 7'($countones(s_axis_tkeep));
    r = n + 7'd6;
    csum = '0;
    for (int i = 0; i < 10; i++) csum = csum + {4'd0, b(14 + 2*i), b(15 + 2*i)};
    fold = {1'b0, csum[15:0]} + {13'd0, csum[19:16]};
    err[0] = {b(12), b(13)} != 16'h0800;
    err[1] = b(14) != 8'h45 || !s_axis_tkeep[57];
    err[2] = b(23) != 8'h11;
    err[3] = {b(36), b(37)} != UDP_DPORT;
    err[4] = fold[15:0] + {15'd0, fold[16]} != 16'hFFFF;
    err[5] = {b(47), b(48), b(49)} != local_qp || {b(51), b(52), b(53)} != psn_q;
  end

  assign hdr_hs = state_q == HDR && s_axis_tvalid;
  assign emit = hdr_hs && s_axis_tlast && err == '0 && n > 7'd58;

  always_comb begin
    state_d = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    if (!rst) begin
      unique case (state_q)
        HDR: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) state_d = s_axis_tlast ? HDR : (|err ? DROP : PAYLOAD);
          m_axis_tvalid = emit;
          m_axis_tlast = emit;
          m_axis_tdata = emit ? {432'd0, s_axis_tdata[511:432]} : '0;
          m_axis_tkeep = emit ? ~(ONES << (n - 7'd58)) : '0;
        end
        PAYLOAD: begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata = {s_axis_tdata[431:0], hold_q};
          m_axis_tkeep = s_axis_tlast ? ~(ONES << r) : ONES;
          m_axis_tlast = s_axis_tlast && r <= 7'd64;
          if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = r > 7'd64 ? FLUSH : HDR;
        end
        FLUSH: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata = {432'd0, hold_q};
          m_axis_tkeep = ~(ONES << fl_n_q);
          m_axis_tlast = 1'b1;
          if (m_axis_tready) state_d = HDR;
        end
        DROP: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) state_d = HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HDR;
      psn_q <= PSN_INIT;
      hold_q <= '0;
      fl_n_q <= '0;
      hdr_valid <= 1'b0;
      hdr_opcode <= '0;
      hdr_psn <= '0;
      hdr_ackreq <= 1'b0;
      hdr_err <= '0;
      rx_good_cnt <= '0;
      rx_drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      hdr_valid <= hdr_hs;
      if (hdr_hs) begin
        hdr_opcode <= b(42);
        hdr_psn <= {b(51), b(52), b(53)};
        hdr_ackreq <= s_axis_tdata[407];
        hdr_err <= err;
        if (err == '0) begin
          psn_q <= psn_q + 24'd1;
          rx_good_cnt <= rx_good_cnt + 16'd1;
          hold_q <= s_axis_tdata[511:432];
        end else rx_drop_cnt <= rx_drop_cnt + 16'd1;
      end
      // the tail of every consumed beat carries over into the next output beat
      if (state_q == PAYLOAD && s_axis_tvalid && m_axis_tready) begin
        hold_q <= s_axis_tdata[511:432];
        fl_n_q <= 3'(n - 7'd58);
      end
    end
  end
endmodule

// File: tb/tb_rroce_pkt_parser.sv
// tb_rroce_pkt_parser: frame-level reference model of the RoCEv2 parser; expected payload is
// simply frame bytes 54..len-5 cut into 64-byte beats, expected errors come from the header rules.
module tb_rroce_pkt_parser;
  localparam logic [23:0] LQP = 24'h000123;
  localparam logic [23:0] PSN0 = 24'h0;
  logic clk = 1'b0;
  logic rst;
  logic [511:0] s_axis_tdata, m_axis_tdata;
  logic [63:0] s_axis_tkeep, m_axis_tkeep;
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [23:0] local_qp;
  logic hdr_valid, hdr_ackreq;
  logic [7:0] hdr_opcode;
  logic [23:0] hdr_psn;
  logic [5:0] hdr_err;
  logic [15:0] rx_good_cnt, rx_drop_cnt;

  rroce_pkt_parser dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .local_qp(local_qp), .hdr_valid(hdr_valid), .hdr_opcode(hdr_opcode), .hdr_psn(hdr_psn),
    .hdr_ackreq(hdr_ackreq), .hdr_err(hdr_err), .rx_good_cnt(rx_good_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  bit toggle_rdy = 1'b0;
  logic [23:0] m_psn = PSN0;
  logic [15:0] m_good = '0, m_drop = '0;
  logic [5:0] e_err;
  logic [7:0] frame[$], frame190[$], ref190[$], out_q[$], e_pay[$];
  logic [63:0] keep_q[$], e_keep[$];
  logic last_q[$];
  logic [5:0] herr_q[$];
  logic [23:0] hpsn_q[$];
  logic [7:0] hop_q[$];
  logic hack_q[$];

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = toggle_rdy ? ~m_axis_tready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      for (int i = 0; i < 64; i++) if (m_axis_tkeep[i]) out_q.push_back(m_axis_tdata[8*i +: 8]);
      keep_q.push_back(m_axis_tkeep);
      last_q.push_back(m_axis_tlast);
    end
    if (hdr_valid) begin
      herr_q.push_back(hdr_err);
      hpsn_q.push_back(hdr_psn);
      hop_q.push_back(hdr_opcode);
      hack_q.push_back(hdr_ackreq);
    end
  end

  function automatic logic [7:0] fb(input int i);
    return (i < frame.size()) ? frame[i] : 8'h00;
  endfunction

  function automatic logic [5:0] exp_err();
    logic [5:0] e;
    int s = 0;
    for (int w = 0; w < 10; w++) s += {fb(14 + 2*w), fb(15 + 2*w)};
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    e[0] = {fb(12), fb(13)} != 16'h0800;
    e[1] = fb(14) != 8'h45 || frame.size() < 58;
    e[2] = fb(23) != 8'h11;
    e[3] = {fb(36), fb(37)} != 16'd4791;
    e[4] = s != 'hFFFF;
    e[5] = {fb(47), fb(48), fb(49)} != LQP || {fb(51), fb(52), fb(53)} != m_psn;
    return e;
  endfunction

  function automatic bit pay_ok();
    if (out_q.size() != e_pay.size()) return 1'b0;
    foreach (out_q[i]) if (out_q[i] !== e_pay[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit shape_ok();
    if (keep_q.size() != e_keep.size()) return 1'b0;
    foreach (keep_q[i]) if (keep_q[i] !== e_keep[i] || last_q[i] !== (i == keep_q.size() - 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_psn(input logic [23:0] p);
    frame[51] = p[23:16];
    frame[52] = p[15:8];
    frame[53] = p[7:0];
  endtask

  task automatic build(input int len, input logic [23:0] psn, input logic [23:0] qp);
    int s = 0;
    frame.delete();
    for (int i = 0; i < (len < 64 ? 64 : len); i++) frame.push_back(8'($urandom));
    frame[12] = 8'h08; frame[13] = 8'h00; frame[14] = 8'h45; frame[23] = 8'h11;
    frame[24] = 8'h00; frame[25] = 8'h00; frame[36] = 8'h12; frame[37] = 8'hB7;
    frame[47] = qp[23:16]; frame[48] = qp[15:8]; frame[49] = qp[7:0];
    set_psn(psn);
    for (int w = 0; w < 10; w++) s += {frame[14 + 2*w], frame[15 + 2*w]};
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    s = ~s & 'hFFFF;
    frame[24] = s[15:8];
    frame[25] = s[7:0];
    while (frame.size() > len) void'(frame.pop_back());
  endtask

  task automatic set_beat(input int b);
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    for (int l = 0; l < 64; l++)
      if (64*b + l < frame.size()) begin
        s_axis_tdata[8*l +: 8] = frame[64*b + l];
        s_axis_tkeep[l] = 1'b1;
      end
    s_axis_tlast = (64*(b + 1) >= frame.size());
  endtask

  task automatic idle_inputs();
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
  endtask

  // drives the current frame, predicts header/payload/counter results, then lets the output drain
  task automatic send();
    int nb, w, p;
    bit hs;
    logic [63:0] k;
    e_err = exp_err();
    e_pay.delete();
    e_keep.delete();
    if (e_err == '0) begin
      for (int i = 54; i <= frame.size() - 5; i++) e_pay.push_back(frame[i]);
      m_psn++;
      m_good++;
    end else m_drop++;
    p = e_pay.size();
    while (p > 0) begin
      k = '0;
      for (int j = 0; j < (p > 64 ? 64 : p); j++) k[j] = 1'b1;
      e_keep.push_back(k);
      p -= 64;
    end
    out_q.delete(); keep_q.delete(); last_q.delete();
    herr_q.delete(); hpsn_q.delete(); hop_q.delete(); hack_q.delete();
    nb = (frame.size() + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      set_beat(b);
      s_axis_tvalid = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        hs = s_axis_tready;
        @(posedge clk);
        #1;
        w++;
      end while (!hs && w < 100);
      if (!hs) begin
        total++;
        $display("FAIL send_timeout beat=%0d s_axis_tready=0 required=1", b);
      end
    end
    idle_inputs();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) $display("FAIL reset_hs tready=%b mvalid=%b mlast=%b required=000", s_axis_tready, m_axis_tvalid, m_axis_tlast);
    else passed++;
    total++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0) $display("FAIL reset_mdata keep=%h required=0", m_axis_tkeep);
    else passed++;
    total++;
    if ({hdr_valid, hdr_opcode, hdr_psn, hdr_ackreq, hdr_err} !== '0) $display("FAIL reset_hdr valid=%b err=%b psn=%h required=0", hdr_valid, hdr_err, hdr_psn);
    else passed++;
    total++;
    if (rx_good_cnt !== 16'd0 || rx_drop_cnt !== 16'd0) $display("FAIL reset_cnt good=%0d drop=%0d required=0", rx_good_cnt, rx_drop_cnt);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (s_axis_tready !== 1'b1 || hdr_valid !== 1'b0) $display("FAIL reset_release tready=%b hdr_valid=%b required=1,0", s_axis_tready, hdr_valid);
    else passed++;
  endtask

  task automatic test_valid_114();
    logic [23:0] p = m_psn;
    build(114, m_psn, LQP);
    send();
    total++;
    if (herr_q.size() !== 1 || herr_q[0] !== 6'd0) $display("FAIL v114_err n=%0d err=%b required=1,000000", herr_q.size(), herr_q[0]);
    else passed++;
    total++;
    if (hpsn_q[0] !== p || hop_q[0] !== frame[42] || hack_q[0] !== frame[50][7]) $display("FAIL v114_fields psn=%h op=%h ack=%b required=%h %h %b", hpsn_q[0], hop_q[0], hack_q[0], p, frame[42], frame[50][7]);
    else passed++;
    total++;
    if (keep_q.size() !== 1 || keep_q[0] !== 64'h00FF_FFFF_FFFF_FFFF || last_q[0] !== 1'b1 || !pay_ok()) $display("FAIL v114_out beats=%0d keep=%h bytes=%0d required=1 00ffffffffffffff 56", keep_q.size(), keep_q[0], out_q.size());
    else passed++;
    total++;
    if (rx_good_cnt !== 16'd1 || rx_drop_cnt !== 16'd0) $display("FAIL v114_cnt good=%0d drop=%0d required=1 0", rx_good_cnt, rx_drop_cnt);
    else passed++;
  endtask

  task automatic test_bad_csum();
    build(114, m_psn, LQP);
    frame[24] ^= 8'hFF;
    send();
    total++;
    if (herr_q.size() !== 1 || herr_q[0] !== 6'b010000) $display("FAIL csum_err n=%0d err=%b required=1,010000", herr_q.size(), herr_q[0]);
    else passed++;
    total++;
    if (keep_q.size() !== 0) $display("FAIL csum_nobeat beats=%0d required=0", keep_q.size());
    else passed++;
    total++;
    if (rx_drop_cnt !== 16'd1 || rx_good_cnt !== m_good) $display("FAIL csum_cnt drop=%0d good=%0d required=1 %0d", rx_drop_cnt, rx_good_cnt, m_good);
    else passed++;
    build(114, m_psn, LQP);
    send();
    total++;
    if (herr_q.size() !== 1 || herr_q[0] !== 6'd0) $display("FAIL csum_psn_kept err=%b required=000000", herr_q[0]);
    else passed++;
    total++;
    if (!pay_ok() || !shape_ok()) $display("FAIL csum_next_out bytes=%0d required=%0d", out_q.size(), e_pay.size());
    else passed++;
  endtask

  task automatic test_190();
    build(190, m_psn, LQP);
    frame190 = frame;
    send();
    ref190 = out_q;
    total++;
    if (herr_q.size() !== 1 || herr_q[0] !== 6'd0) $display("FAIL f190_err err=%b required=000000", herr_q[0]);
    else passed++;
    total++;
    if (keep_q.size() !== 3 || keep_q[0] !== '1 || keep_q[1] !== '1 || keep_q[2] !== 64'hF ||
        last_q[0] !== 1'b0 || last_q[1] !== 1'b0 || last_q[2] !== 1'b1) $display("FAIL f190_shape beats=%0d keep2=%h required=3 f", keep_q.size(), keep_q[2]);
    else passed++;
    total++;
    if (!pay_ok()) $display("FAIL f190_bytes bytes=%0d required=%0d", out_q.size(), e_pay.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    bit same;
    frame = frame190;
    set_psn(m_psn);
    toggle_rdy = 1'b1;
    send();
    toggle_rdy = 1'b0;
    same = out_q.size() == ref190.size();
    foreach (out_q[i]) if (i < ref190.size() && out_q[i] !== ref190[i]) same = 1'b0;
    total++;
    if (!same) $display("FAIL bp_bytes bytes=%0d required=%0d (unstalled copy)", out_q.size(), ref190.size());
    else passed++;
    total++;
    if (!shape_ok()) $display("FAIL bp_shape beats=%0d required=%0d", keep_q.size(), e_keep.size());
    else passed++;
    total++;
    if (rx_good_cnt !== m_good) $display("FAIL bp_cnt good=%0d required=%0d", rx_good_cnt, m_good);
    else passed++;
  endtask

  task automatic test_psn_seq();
    logic [23:0] base = m_psn;
    build(114, base, LQP);
    send();
    total++;
    if (herr_q[0] !== 6'd0 || !pay_ok()) $display("FAIL psn0 err=%b required=000000", herr_q[0]);
    else passed++;
    build(114, base + 24'd1, LQP);
    send();
    total++;
    if (herr_q[0] !== 6'd0 || !pay_ok()) $display("FAIL psn1 err=%b required=000000", herr_q[0]);
    else passed++;
    build(114, base + 24'd5, LQP);
    send();
    total++;
    if (herr_q.size() !== 1 || herr_q[0] !== 6'b100000 || keep_q.size() !== 0) $display("FAIL psn5 err=%b beats=%0d required=100000 0", herr_q[0], keep_q.size());
    else passed++;
    total++;
    if (rx_good_cnt !== m_good || rx_drop_cnt !== m_drop) $display("FAIL psn_cnt good=%0d drop=%0d required=%0d %0d", rx_good_cnt, rx_drop_cnt, m_good, m_drop);
    else passed++;
  endtask

  task automatic test_reset_mid();
    frame = frame190;
    set_psn(m_psn);
    set_beat(0);
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    set_beat(1);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, hdr_valid, hdr_ackreq} !== 5'd0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0) $display("FAIL rstmid_stream tready=%b mvalid=%b keep=%h required=0", s_axis_tready, m_axis_tvalid, m_axis_tkeep);
    else passed++;
    total++;
    if ({hdr_opcode, hdr_psn, hdr_err, rx_good_cnt, rx_drop_cnt} !== '0) $display("FAIL rstmid_regs err=%b good=%0d drop=%0d required=0", hdr_err, rx_good_cnt, rx_drop_cnt);
    else passed++;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_psn = PSN0;
    m_good = '0;
    m_drop = '0;
    @(posedge clk);
    #1;
    build(114, m_psn, LQP);
    send();
    total++;
    if (herr_q.size() !== 1 || herr_q[0] !== 6'd0) $display("FAIL rstmid_next_err n=%0d err=%b required=1,000000", herr_q.size(), herr_q[0]);
    else passed++;
    total++;
    if (!pay_ok() || !shape_ok()) $display("FAIL rstmid_next_out bytes=%0d required=%0d", out_q.size(), e_pay.size());
    else passed++;
    total++;
    if (rx_good_cnt !== 16'd1 || rx_drop_cnt !== 16'd0) $display("FAIL rstmid_cnt good=%0d drop=%0d required=1 0", rx_good_cnt, rx_drop_cnt);
    else passed++;
  endtask

  task automatic test_single_beat();
    build(64, m_psn, LQP);
    send();
    total++;
    if (herr_q[0] !== 6'd0 || keep_q.size() !== 1 || keep_q[0] !== 64'h3F || last_q[0] !== 1'b1 || !pay_ok()) $display("FAIL sb64 beats=%0d keep=%h required=1 3f", keep_q.size(), keep_q[0]);
    else passed++;
    build(58, m_psn, LQP);
    send();
    total++;
    if (herr_q.size() !== 1 || herr_q[0] !== 6'd0 || keep_q.size() !== 0) $display("FAIL sb58 err=%b beats=%0d required=000000 0", herr_q[0], keep_q.size());
    else passed++;
    total++;
    if (rx_good_cnt !== m_good) $display("FAIL sb58_cnt good=%0d required=%0d", rx_good_cnt, m_good);
    else passed++;
    build(40, m_psn, LQP);
    send();
    total++;
    if (herr_q.size() !== 1 || herr_q[0][1] !== 1'b1 || keep_q.size() !== 0) $display("FAIL sb40 err=%b beats=%0d required=xxxx1x 0", herr_q[0], keep_q.size());
    else passed++;
    total++;
    if (rx_drop_cnt !== m_drop || rx_good_cnt !== m_good) $display("FAIL sb40_cnt drop=%0d good=%0d required=%0d %0d", rx_drop_cnt, rx_good_cnt, m_drop, m_good);
    else passed++;
  endtask

  task automatic test_random();
    int len, c;
    for (int t = 0; t < 30; t++) begin
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(40, 64)) : int'($urandom_range(58, 260));
      c = $urandom_range(0, 11);
      build(len, m_psn, LQP);
      if (frame.size() >= 54)
        case (c)
          1: frame[13] ^= 8'h01;
          2: frame[14] = 8'h46;
          3: frame[23] = 8'h06;
          4: frame[37] ^= 8'h01;
          5: frame[25] ^= 8'h5A;
          6: frame[49] ^= 8'h01;
          7: frame[53] ^= 8'h04;
          default: ;
        endcase
      toggle_rdy = 1'($urandom_range(0, 1));
      send();
      toggle_rdy = 1'b0;
      total++;
      if (herr_q.size() !== 1 || herr_q[0] !== e_err) $display("FAIL rand%0d_err len=%0d n=%0d err=%b required=%b", t, len, herr_q.size(), herr_q[0], e_err);
      else passed++;
      total++;
      if (!pay_ok() || !shape_ok()) $display("FAIL rand%0d_out len=%0d bytes=%0d beats=%0d required=%0d %0d", t, len, out_q.size(), keep_q.size(), e_pay.size(), e_keep.size());
      else passed++;
      total++;
      if (rx_good_cnt !== m_good || rx_drop_cnt !== m_drop) $display("FAIL rand%0d_cnt good=%0d drop=%0d required=%0d %0d", t, rx_good_cnt, rx_drop_cnt, m_good, m_drop);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    local_qp = LQP;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_valid_114();
    test_bad_csum();
    test_190();
    test_backpressure();
    test_psn_seq();
    test_single_beat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
